if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, next-PC selection, synchronous instruction-memory addressing and the IF/ID pipeline register.
- Directly upstream of ID and the hazard detection unit; consumes that unit's PC_Write_en / IF_ID_Write_en stall controls and the EX-stage branch/jump redirect.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush/reset (addi x0,x0,0)
CNT_W, 32, width of the stall and flush event counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
PC_Write_en  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
IF_ID_Write_en  input  1  1 = IF/ID captures; 0 = hold IF/ID
PC_Src  input  1  1 = taken branch/jump resolved in EX; redirect to PC_Target
PC_Target  input  32  redirect address from EX
IF_ID_Flush  input  1  external squash of the IF/ID contents
imem_addr  output  32  word-aligned address to synchronous IMEM; read data returns next cycle
imem_rdata  input  32  IMEM read data for the address presented last cycle
ID_PC  output  32  PC of the instruction in IF/ID
ID_PC4  output  32  ID_PC + 4
ID_Instr  output  32  instruction in IF/ID
ID_Valid  output  1  1 = IF/ID holds a real instruction
stall_cnt  output  CNT_W  cycles with PC_Write_en=0 and PC_Src=0
flush_cnt  output  CNT_W  cycles in which IF/ID was flushed

Behaviour:
- Reset (rst=1 at posedge): PC<=RESET_PC, ID_PC<=RESET_PC, ID_PC4<=RESET_PC+4, ID_Instr<=NOP_INSTR, ID_Valid<=0, stall_cnt<=0, flush_cnt<=0.
- Reset has priority over every other input.
- Reset asserted mid-operation discards all state in that same cycle; no partial update.
- While rst=1, imem_addr=RESET_PC (combinational). The first cycle after reset release therefore sees imem_rdata valid for RESET_PC.
- Next PC, combinational, priority order:
  - rst: RESET_PC
  - PC_Src=1: {PC_Target[31:2],2'b00}; redirect wins over PC_Write_en=0.
  - PC_Write_en=0: PC (hold)
  - otherwise: PC+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr = next PC (combinational). PC <= next PC every cycle.
- Invariant: imem_rdata always corresponds to the current PC. During a hold, IMEM re-reads the same address, so the data stays valid with no skid buffer.
- IF/ID register, priority order:
  - rst: reset values above.
  - IF_ID_Flush=1 or PC_Src=1: ID_Instr<=NOP_INSTR, ID_Valid<=0, ID_PC/ID_PC4<=current PC/PC+4. Applies regardless of IF_ID_Write_en.
  - IF_ID_Write_en=1: ID_PC<=PC, ID_PC4<=PC+4, ID_Instr<=imem_rdata, ID_Valid<=1.
  - else: hold all IF/ID outputs.
- Latency: an instruction at address A appears on ID_Instr 2 cycles after A is driven on imem_addr (1 cycle IMEM read, 1 cycle IF/ID register).
- Redirect penalty: the instruction in IF is squashed in the PC_Src cycle. The target instruction reaches ID 2 cycles after PC_Src.
- stall_cnt increments when PC_Write_en=0 and PC_Src=0.
- flush_cnt increments when IF_ID_Flush=1 or PC_Src=1.
- Both counters saturate at all-ones and do not wrap.
- Outputs are registered, except imem_addr.

Test Plan:
1. Reset then free-run with PC_Write_en=IF_ID_Write_en=1, IMEM word[i]=i -> imem_addr=0,4,8...; one cycle after the first capture ID_PC=0, ID_Instr=0, ID_Valid=1; next cycle ID_PC=4, ID_Instr=1.
2. Load-use stall: at PC=0x10, drive PC_Write_en=IF_ID_Write_en=0 for 1 cycle -> PC and IF/ID hold; ID_PC stays 0x0C for 2 cycles; then 0x10 is captured with correct data; stall_cnt=1.
3. Redirect: PC_Src=1, PC_Target=0x103 at PC=0x20 -> next imem_addr=0x100; ID_Valid=0 and ID_Instr=0x13 next cycle; the instruction at 0x100 reaches ID the cycle after; flush_cnt=1.
4. Simultaneous PC_Src=1 and PC_Write_en=0 -> redirect wins, PC=target, stall_cnt unchanged.
5. Wrap: PC=0xFFFF_FFFC advancing -> PC=0; ID_PC4 for 0xFFFF_FFFC equals 0.
6. rst asserted for 1 cycle mid-stream with pending stall -> PC=RESET_PC, ID_Valid=0, counters 0; fetch restarts at RESET_PC; counter saturation checked with CNT_W=2 (stall 5 cycles -> stall_cnt=3).

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IMEM addressing,
// IF/ID pipeline register and saturating stall/flush event counters.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   PC_Write_en      1 = PC may advance, 0 = hold PC
//   IF_ID_Write_en   1 = IF/ID captures, 0 = IF/ID holds
//   PC_Src           redirect to PC_Target (taken branch/jump from EX)
//   PC_Target        redirect address, low two bits ignored
//   IF_ID_Flush      squash IF/ID contents
//   imem_addr        next PC, presented to synchronous IMEM
//   imem_rdata       IMEM data for the address presented last cycle
//   ID_PC/ID_PC4     PC of the IF/ID instruction and PC+4
//   ID_Instr         IF/ID instruction
//   ID_Valid         IF/ID holds a real instruction
//   stall_cnt        cycles with PC_Write_en=0 and PC_Src=0
//   flush_cnt        cycles in which IF/ID was flushed
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Write_en,
    input  logic             IF_ID_Write_en,
    input  logic             PC_Src,
    input  logic [31:0]      PC_Target,
    input  logic             IF_ID_Flush,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_PC4,
    output logic [31:0]      ID_Instr,
    output logic             ID_Valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0] RESET_PC4 = RESET_PC + 32'd4;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        stall_ev;
    logic        flush_ev;

    assign pc_plus4 = pc + 32'd4;
    assign stall_ev = !PC_Write_en && !PC_Src;
    assign flush_ev = IF_ID_Flush || PC_Src;

    // Redirect beats a stall: the stalled instruction is on the wrong path.
    always_comb begin
        next_pc = pc_plus4;
        if (rst)
            next_pc = RESET_PC;
        else if (PC_Src)
            next_pc = {PC_Target[31:2], 2'b00};
        else if (!PC_Write_en)
            next_pc = pc;
    end

    // Holding PC re-presents the same address, so imem_rdata
    // always matches pc without a skid buffer.
    assign imem_addr = next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ID_PC     <= RESET_PC;
            ID_PC4    <= RESET_PC4;
            ID_Instr  <= NOP_INSTR;
            ID_Valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            pc <= next_pc;

            if (flush_ev) begin
                ID_PC    <= pc;
                ID_PC4   <= pc_plus4;
                ID_Instr <= NOP_INSTR;
                ID_Valid <= 1'b0;
            end else if (IF_ID_Write_en) begin
                ID_PC    <= pc;
                ID_PC4   <= pc_plus4;
                ID_Instr <= imem_rdata;
                ID_Valid <= 1'b1;
            end

            if (stall_ev && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
